serial_adder: RTL

Bit-serial adder that computes `{carry, sum} = a + b` for two WIDTH-bit operands, one bit per clock, LSB first. Each cycle's bit addition is built from two half-adder cells plus an OR, with a registered carry between cycles. It sits between the operand source and any consumer that needs a sum but can tolerate WIDTH-cycle latency. It trades area for time against a parallel ripple adder.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. Computes {carry, sum} = a + b for two WIDTH-bit
// operands, one bit per clock, LSB first. Each bit is added by two half-adder
// cells plus an OR. A register carries the carry between cycles. The result
// appears WIDTH cycles after a start is accepted. It then holds until the next
// completion.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset, clears all state
//   start  in   1      begin an addition (accepted in IDLE or DONE only)
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse when sum/carry are updated
//   sum    out  WIDTH  registered low WIDTH bits of a+b
//   carry  out  1      registered carry-out of the MSB
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic             c;
   logic [CW-1:0]    cnt;

   // One full-adder bit built from two half-adder cells and an OR.
   logic h1_s, h1_c, h2_s, h2_c, c_next;

   assign h1_s   = a_sh[0] ^ b_sh[0];
   assign h1_c   = a_sh[0] & b_sh[0];
   assign h2_s   = h1_s ^ c;
   assign h2_c   = h1_s & c;
   assign c_next = h1_c | h2_c;

   assign last = (cnt == LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         // NOTE: registers use non-blocking assignments. Every flop then
         // samples pre-edge values, whatever order the blocks evaluate in.
         state <= state_nx;
      end
   end

   // Next state and outputs. busy and done decode directly from the state.
   // They are therefore mutually exclusive and go low as soon as reset
   // is asserted.
   always_comb begin
      // NOTE: defaults come first. Then every path assigns every output, and
      // no latch is inferred.
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            accept   = start;
            state_nx = start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand shifters, carry, bit counter, sum shifter, result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every register here is cleared, including the internal
         // shifters. A run cut short by reset leaves no partial result behind.
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         carry  <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         sum_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         sum_sh <= {h2_s, sum_sh[WIDTH-1:1]};
         c      <= c_next;
         cnt    <= cnt + 1'b1;
         // The final bit goes straight into the output register. The result
         // is then visible on the same edge that enters DONE.
         if (last) begin
            sum   <= {h2_s, sum_sh[WIDTH-1:1]};
            carry <= c_next;
         end
      end
   end

endmodule
